// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Brief    : Shared pointer-width constant and Gray/binary conversions for the
//            dual-clock FIFO read and write controllers.
// Revision : 1.0
// ============================================================================
package fifo_pkg;

    // Conversions operate on a fixed wide word; callers zero-extend/truncate.
    localparam int PTR_W_MAX = 32;

    typedef logic [PTR_W_MAX-1:0] ptr_word_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic ptr_word_t bin2gray(input ptr_word_t bin);
        ptr_word_t gray;
        gray = '0;
        gray[PTR_W_MAX-1] = bin[PTR_W_MAX-1];
        for (int i = 0; i < PTR_W_MAX - 1; i++) begin
            gray[i] = bin[i] ^ bin[i+1];
        end
        return gray;
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t gray);
        ptr_word_t bin;
        bin = '0;
        bin[PTR_W_MAX-1] = gray[PTR_W_MAX-1];
        for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_sync_bus.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_bus
// Brief    : Multi-bit flop chain for carrying Gray pointers across domains.
// Revision : 1.0
// ============================================================================
module fifo_sync_bus #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule : fifo_sync_bus
`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_ctrl
// Brief    : Read-side controller of the dual-clock FIFO: read pointers,
//            synchronised write pointer, registered empty/level/underflow.
// Revision : 1.0
// ============================================================================
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int AE_LEVEL    = 2
) (
    input  logic                   R_CLK,
    input  logic                   R_RST,
    input  logic                   R_INC,
    input  logic [$clog2(DEPTH):0] gray_Wptr,
    output logic [$clog2(DEPTH)-1:0] Raddr,
    output logic [$clog2(DEPTH):0] gray_Rptr,
    output logic                   REMPTY,
    output logic                   RAEMPTY,
    output logic [$clog2(DEPTH):0] RLEVEL,
    output logic                   RUNDERFLOW
);

    localparam int A  = $clog2(DEPTH);
    localparam int PW = A + 1;

    logic [PW-1:0] wq;
    logic [PW-1:0] wbin;

    logic [PW-1:0] rptr_q,      rptr_d;
    logic [PW-1:0] gray_rptr_q, gray_rptr_d;
    logic [PW-1:0] rlevel_q,    rlevel_d;
    logic          rempty_q,    rempty_d;
    logic          raempty_q,   raempty_d;
    logic          runder_q,    runder_d;
    logic          rd_en;

    fifo_sync_bus #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk_i (R_CLK),
        .rst_i (R_RST),
        .d_i   (gray_Wptr),
        .q_o   (wq)
    );

    assign wbin = PW'(gray2bin(PTR_W_MAX'(wq)));

    // Flags and level are computed from the post-read pointer so they never
    // lag the pointer that the consumer and the write side observe.
    always_comb begin
        rd_en       = R_INC & ~rempty_q;
        rptr_d      = rptr_q + PW'(rd_en);
        gray_rptr_d = PW'(bin2gray(PTR_W_MAX'(rptr_d)));
        rempty_d    = (gray_rptr_d == wq);
        rlevel_d    = wbin - rptr_d;
        raempty_d   = (rlevel_d <= PW'(AE_LEVEL));
        runder_d    = R_INC & rempty_q;
    end

    always_ff @(posedge R_CLK or posedge R_RST) begin
        if (R_RST) begin
            rptr_q      <= '0;
            gray_rptr_q <= '0;
            rlevel_q    <= '0;
            rempty_q    <= 1'b1;
            raempty_q   <= 1'b1;
            runder_q    <= 1'b0;
        end else begin
            rptr_q      <= rptr_d;
            gray_rptr_q <= gray_rptr_d;
            rlevel_q    <= rlevel_d;
            rempty_q    <= rempty_d;
            raempty_q   <= raempty_d;
            runder_q    <= runder_d;
        end
    end

    assign Raddr      = rptr_q[A-1:0];
    assign gray_Rptr  = gray_rptr_q;
    assign REMPTY     = rempty_q;
    assign RAEMPTY    = raempty_q;
    assign RLEVEL     = rlevel_q;
    assign RUNDERFLOW = runder_q;

endmodule : fifo_rd_ctrl
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_ctrl
// Brief    : Self-checking bench for fifo_rd_ctrl against a word-count model.
// Revision : 1.0
// ============================================================================
module tb_fifo_rd_ctrl;

    localparam int DEPTH = 16;
    localparam int SYNC  = 2;
    localparam int AE    = 2;
    localparam int PW    = 5;

    logic          R_CLK = 1'b0;
    logic          R_RST = 1'b0;
    logic          R_INC = 1'b0;
    logic [PW-1:0] gray_Wptr = '0;
    logic [3:0]    Raddr;
    logic [PW-1:0] gray_Rptr;
    logic          REMPTY;
    logic          RAEMPTY;
    logic [PW-1:0] RLEVEL;
    logic          RUNDERFLOW;

    int total = 0;
    int bad   = 0;

    // Model: words written (as driven) and words read, both modulo 32.
    int   m_wr;
    int   m_rd;
    int   hist [SYNC];
    int   m_level;
    logic m_empty;
    logic m_aempty;
    logic m_uf;

    fifo_rd_ctrl #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC),
        .AE_LEVEL    (AE)
    ) dut (
        .R_CLK      (R_CLK),
        .R_RST      (R_RST),
        .R_INC      (R_INC),
        .gray_Wptr  (gray_Wptr),
        .Raddr      (Raddr),
        .gray_Rptr  (gray_Rptr),
        .REMPTY     (REMPTY),
        .RAEMPTY    (RAEMPTY),
        .RLEVEL     (RLEVEL),
        .RUNDERFLOW (RUNDERFLOW)
    );

    always #5 R_CLK = ~R_CLK;

    wire [16:0] dut_vec = {Raddr, gray_Rptr, REMPTY, RAEMPTY, RLEVEL, RUNDERFLOW};

    function automatic logic [4:0] g(input int b);
        int x;
        x = b & 31;
        return 5'(x ^ (x >> 1));
    endfunction

    function automatic logic [16:0] exp_vec();
        return {4'(m_rd % 16), g(m_rd), m_empty, m_aempty, 5'(m_level), m_uf};
    endfunction

    task automatic model_reset();
        m_rd = 0;
        for (int i = 0; i < SYNC; i++) hist[i] = 0;
        m_level  = 0;
        m_empty  = 1'b1;
        m_aempty = 1'b1;
        m_uf     = 1'b0;
    endtask

    task automatic set_w(input int v);
        m_wr      = v & 31;
        gray_Wptr = g(m_wr);
    endtask

    // One read-clock edge: the write count seen by the flags is the one
    // driven SYNC edges earlier; reads are honoured only when not empty.
    task automatic tick();
        int vis;
        @(posedge R_CLK);
        if (R_RST) begin
            model_reset();
        end else begin
            vis  = hist[SYNC-1];
            m_uf = R_INC && m_empty;
            if (R_INC && !m_empty) m_rd = (m_rd + 1) & 31;
            m_level  = (vis - m_rd) & 31;
            m_empty  = (m_level == 0);
            m_aempty = (m_level <= AE);
            for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = m_wr;
        end
        #1;
    endtask

    task automatic test_reset();
        gray_Wptr = 5'b00101;
        #2 R_RST = 1'b1;
        #1;
        total++; if (REMPTY !== 1'b1)     begin bad++; $display("FAIL rst_empty got=%b exp=1", REMPTY); end
        total++; if (RAEMPTY !== 1'b1)    begin bad++; $display("FAIL rst_aempty got=%b exp=1", RAEMPTY); end
        total++; if (RLEVEL !== 5'd0)     begin bad++; $display("FAIL rst_level got=%0d exp=0", RLEVEL); end
        total++; if (Raddr !== 4'd0)      begin bad++; $display("FAIL rst_raddr got=%0d exp=0", Raddr); end
        total++; if (gray_Rptr !== 5'd0)  begin bad++; $display("FAIL rst_grayr got=%b exp=00000", gray_Rptr); end
        total++; if (RUNDERFLOW !== 1'b0) begin bad++; $display("FAIL rst_uf got=%b exp=0", RUNDERFLOW); end
        set_w(0);
        model_reset();
        tick();
        tick();
        R_RST = 1'b0;
        tick();
        total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL post_rst got=%h exp=%h", dut_vec, exp_vec()); end
    endtask

    task automatic test_single_write();
        set_w(1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL single_vec c=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
            total++; if (REMPTY !== (c < 3)) begin bad++; $display("FAIL single_empty c=%0d got=%b exp=%b", c, REMPTY, (c < 3)); end
            total++; if (RAEMPTY !== 1'b1) begin bad++; $display("FAIL single_aempty c=%0d got=%b exp=1", c, RAEMPTY); end
        end
        total++; if (RLEVEL !== 5'd1) begin bad++; $display("FAIL single_level got=%0d exp=1", RLEVEL); end
    endtask

    task automatic test_drain_underflow();
        for (int v = 2; v <= 5; v++) begin
            set_w(v);
            tick();
            total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL fill_vec v=%0d got=%h exp=%h", v, dut_vec, exp_vec()); end
        end
        for (int c = 0; c < 3; c++) tick();
        total++; if (RLEVEL !== 5'd5) begin bad++; $display("FAIL drain_start got=%0d exp=5", RLEVEL); end
        R_INC = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL drain_vec i=%0d got=%h exp=%h", i, dut_vec, exp_vec()); end
            if (i <= 5) begin
                total++;
                if (Raddr !== 4'(i) || RLEVEL !== 5'(5 - i) || REMPTY !== (i == 5) ||
                    RAEMPTY !== ((5 - i) <= 2) || RUNDERFLOW !== 1'b0) begin
                    bad++;
                    $display("FAIL drain_step i=%0d got addr=%0d lvl=%0d e=%b ae=%b uf=%b", i, Raddr, RLEVEL, REMPTY, RAEMPTY, RUNDERFLOW);
                end
            end else begin
                total++;
                if (RUNDERFLOW !== 1'b1 || Raddr !== 4'd5) begin
                    bad++;
                    $display("FAIL underflow got uf=%b addr=%0d exp uf=1 addr=5", RUNDERFLOW, Raddr);
                end
            end
        end
        R_INC = 1'b0;
        tick();
        total++; if (RUNDERFLOW !== 1'b0) begin bad++; $display("FAIL uf_pulse got=%b exp=0", RUNDERFLOW); end
    endtask

    task automatic test_wrap_random();
        int            wraps;
        int            occ;
        logic [PW-1:0] prev;
        wraps = 0;
        for (int c = 0; c < 400; c++) begin
            R_INC = 1'($urandom % 2);
            occ = (m_wr - m_rd) & 31;
            if (occ < DEPTH && ($urandom % 2) == 1) set_w(m_wr + 1);
            prev = gray_Rptr;
            tick();
            total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL rand_vec c=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
            if (prev == 5'b10000 && gray_Rptr == 5'b00000) wraps++;
        end
        R_INC = 1'b0;
        total++; if (wraps == 0) begin bad++; $display("FAIL wrap_seen got=%0d exp>0", wraps); end
    endtask

    task automatic test_full();
        for (int c = 0; c < 40 && ((m_wr - m_rd) & 31) < DEPTH; c++) begin
            set_w(m_wr + 1);
            tick();
            total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL full_vec c=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
        end
        for (int c = 0; c < 3; c++) tick();
        total++;
        if (RLEVEL !== 5'b10000 || REMPTY !== 1'b0 || RAEMPTY !== 1'b0) begin
            bad++;
            $display("FAIL full got lvl=%b e=%b ae=%b exp lvl=10000 e=0 ae=0", RLEVEL, REMPTY, RAEMPTY);
        end
    endtask

    task automatic test_reset_mid();
        R_INC = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tick();
            total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL pre_rst_vec c=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
        end
        R_INC = 1'b0;
        total++; if (RLEVEL !== 5'd7) begin bad++; $display("FAIL mid_level got=%0d exp=7", RLEVEL); end
        #3 R_RST = 1'b1;
        #1;
        total++;
        if (dut_vec !== {4'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0}) begin
            bad++;
            $display("FAIL mid_rst got=%h exp=%h", dut_vec, {4'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0});
        end
        set_w(0);
        model_reset();
        tick();
        tick();
        R_RST = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++; if (REMPTY !== 1'b1) begin bad++; $display("FAIL rst_resume c=%0d got=%b exp=1", c, REMPTY); end
            total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL resume_vec c=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
        end
    endtask

    initial begin
        m_wr = 0;
        model_reset();
        test_reset();
        test_single_write();
        test_drain_underflow();
        test_wrap_random();
        test_full();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule : tb_fifo_rd_ctrl
`default_nettype wire
